// File: rtl/img_pkg.sv
// Shared definitions for the frame packetiser: FSM state encoding, trailer
// word offsets, and the bit layout of trailer info word dw0.
package img_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_DATA = 3'd1,
        PAD     = 3'd2,
        TRAILER = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int unsigned TYPE_W        = 2;
    localparam int unsigned SEQ_W         = 32;
    localparam int unsigned INFO_W        = 32;

    // Trailer word offsets
    localparam int unsigned PARITY_OFS    = 0;
    localparam int unsigned INFO_OFS      = 4;

    // dw0 bit positions
    localparam int unsigned DW0_TYPE_LSB  = 8;
    localparam int unsigned DW0_SHORT_BIT = 16;
    localparam int unsigned DW0_OVF_BIT   = 17;

    // Assemble trailer info word dw0 (zero-extended by the caller to DATA_W)
    function automatic logic [INFO_W-1:0] make_dw0(input logic [TYPE_W-1:0] ftype,
                                                   input logic short_flag,
                                                   input logic ovf_flag);
        logic [INFO_W-1:0] w;
        w = '0;
        w[DW0_TYPE_LSB +: TYPE_W] = ftype;
        w[DW0_SHORT_BIT]          = short_flag;
        w[DW0_OVF_BIT]            = ovf_flag;
        return w;
    endfunction

endpackage

// File: rtl/img_parity_acc.sv
// Clearable running-XOR accumulator over the data words of one frame.
// Ports: clk, rst_n (sync, active low), clear (zero the accumulator),
//        enable (fold data into the accumulator), data, parity (result).
module img_parity_acc #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              enable,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] parity
);

    // Clear takes priority so a new frame always starts from zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parity <= '0;
        end else if (clear) begin
            parity <= '0;
        end else if (enable) begin
            parity <= parity ^ data;
        end
    end

endmodule

// File: rtl/img_packet_param.sv
// Frame packetiser: writes each selected frame into the DDR write FIFO as
// IMG_WORDS data words followed by a LINE_WORDS-word trailer (parity, info
// words, zero padding). Short frames are zero-padded and flagged.
// Ports: clk, rst_n (sync, active low); data_in/data_in_valid pixel stream;
//        frame_start/frame_type_i frame marker and type; store_type_mask and
//        wr2ddr_en store selection; overflow_clr clears fifo_overflow;
//        fifo_wrdata/fifo_wren/fifo_full FIFO interface; fifo_overflow,
//        frame_store, frame_type_o, frame_seq_o, short_frame_o status.
module img_packet_param
    import img_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned IMG_WORDS  = 262144,
    parameter int unsigned LINE_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_in_valid,
    input  logic              frame_start,
    input  logic [1:0]        frame_type_i,
    input  logic [3:0]        store_type_mask,
    input  logic              wr2ddr_en,
    input  logic              overflow_clr,
    output logic [DATA_W-1:0] fifo_wrdata,
    output logic              fifo_wren,
    input  logic              fifo_full,
    output logic              fifo_overflow,
    output logic              frame_store,
    output logic [1:0]        frame_type_o,
    output logic [31:0]       frame_seq_o,
    output logic              short_frame_o
);

    localparam int unsigned CNT_W  = $clog2(IMG_WORDS + 1);
    localparam int unsigned TCNT_W = $clog2(LINE_WORDS);

    // Input stage
    logic [DATA_W-1:0] data_in_q;
    logic              valid_q;
    logic              frame_start_q;
    logic              frame_start_qq;
    logic [1:0]        frame_type_q;
    logic              wr2ddr_en_q;

    // Frame state
    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [CNT_W-1:0]  acc_cnt, acc_cnt_d;
    logic [TCNT_W-1:0] tcnt, tcnt_d;
    logic              store_r, store_d;
    logic              short_flag, short_flag_d;
    logic              ovf_frame, ovf_frame_d;
    logic [1:0]        cur_type, cur_type_d;

    // Next values of registered outputs
    logic [DATA_W-1:0] fifo_wrdata_d;
    logic              fifo_wren_d;
    logic              fifo_overflow_d;
    logic              frame_store_d;
    logic [1:0]        frame_type_o_d;
    logic [31:0]       frame_seq_d;
    logic              short_frame_d;

    logic              rise;
    logic              ovf_set;
    logic              par_clr;
    logic              par_en;
    logic [DATA_W-1:0] parity;
    logic [DATA_W-1:0] trailer_word;

    assign rise = frame_start_q & ~frame_start_qq;

    img_parity_acc #(
        .DATA_W (DATA_W)
    ) u_parity (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (par_clr),
        .enable (par_en),
        .data   (data_in_q),
        .parity (parity)
    );

    // Trailer word selection; dw1 already reflects this frame's sequence bump
    always_comb begin
        trailer_word = '0;
        if (tcnt == TCNT_W'(PARITY_OFS)) begin
            trailer_word = parity;
        end else if (tcnt == TCNT_W'(INFO_OFS)) begin
            trailer_word = DATA_W'(make_dw0(cur_type, short_flag, ovf_frame));
        end else if (tcnt == TCNT_W'(INFO_OFS + 1)) begin
            trailer_word = DATA_W'(frame_seq_o + 32'(store_r));
        end else if (tcnt == TCNT_W'(INFO_OFS + 2)) begin
            trailer_word = DATA_W'(acc_cnt);
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d         = state;
        cnt_d           = cnt;
        acc_cnt_d       = acc_cnt;
        tcnt_d          = tcnt;
        store_d         = store_r & wr2ddr_en_q;
        short_flag_d    = short_flag;
        ovf_frame_d     = ovf_frame;
        cur_type_d      = cur_type;
        fifo_wrdata_d   = fifo_wrdata;
        fifo_wren_d     = 1'b0;
        frame_store_d   = 1'b0;
        frame_type_o_d  = rise ? frame_type_q : frame_type_o;
        frame_seq_d     = frame_seq_o;
        short_frame_d   = short_frame_o;
        ovf_set         = 1'b0;
        par_clr         = 1'b0;
        par_en          = 1'b0;

        case (state)
            IDLE: begin
                if (rise) begin
                    state_d      = WR_DATA;
                    cnt_d        = '0;
                    acc_cnt_d    = '0;
                    tcnt_d       = '0;
                    short_flag_d = 1'b0;
                    ovf_frame_d  = 1'b0;
                    cur_type_d   = frame_type_q;
                    par_clr      = 1'b1;
                    store_d      = wr2ddr_en_q & store_type_mask[frame_type_q];
                end
            end
            WR_DATA: begin
                // A word dropped on fifo_full still counts and enters parity
                if (valid_q) begin
                    par_en    = 1'b1;
                    cnt_d     = cnt + CNT_W'(1);
                    acc_cnt_d = acc_cnt + CNT_W'(1);
                    if (store_r) begin
                        if (fifo_full) begin
                            ovf_set     = 1'b1;
                            ovf_frame_d = 1'b1;
                        end else begin
                            fifo_wren_d   = 1'b1;
                            fifo_wrdata_d = data_in_q;
                        end
                    end
                end
                if (valid_q && cnt == CNT_W'(IMG_WORDS - 1)) begin
                    state_d = TRAILER;
                end else if (rise) begin
                    short_flag_d = 1'b1;
                    state_d      = PAD;
                end
            end
            PAD: begin
                if (!fifo_full) begin
                    cnt_d = cnt + CNT_W'(1);
                    if (store_r) begin
                        fifo_wren_d   = 1'b1;
                        fifo_wrdata_d = '0;
                    end
                    if (cnt == CNT_W'(IMG_WORDS - 1)) begin
                        state_d = TRAILER;
                    end
                end
            end
            TRAILER: begin
                if (!fifo_full) begin
                    tcnt_d = tcnt + TCNT_W'(1);
                    if (store_r) begin
                        fifo_wren_d   = 1'b1;
                        fifo_wrdata_d = trailer_word;
                    end
                    if (tcnt == TCNT_W'(LINE_WORDS - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (store_r) begin
                    frame_seq_d   = frame_seq_o + 32'd1;
                    frame_store_d = 1'b1;
                    short_frame_d = short_flag;
                end
                store_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Set wins over a simultaneous clear
        fifo_overflow_d = ovf_set ? 1'b1 : (overflow_clr ? 1'b0 : fifo_overflow);
    end

    // State, input stage and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_in_q      <= '0;
            valid_q        <= 1'b0;
            frame_start_q  <= 1'b0;
            frame_start_qq <= 1'b0;
            frame_type_q   <= '0;
            wr2ddr_en_q    <= 1'b0;
            state          <= IDLE;
            cnt            <= '0;
            acc_cnt        <= '0;
            tcnt           <= '0;
            store_r        <= 1'b0;
            short_flag     <= 1'b0;
            ovf_frame      <= 1'b0;
            cur_type       <= '0;
            fifo_wrdata    <= '0;
            fifo_wren      <= 1'b0;
            fifo_overflow  <= 1'b0;
            frame_store    <= 1'b0;
            frame_type_o   <= '0;
            frame_seq_o    <= '0;
            short_frame_o  <= 1'b0;
        end else begin
            data_in_q      <= data_in;
            valid_q        <= data_in_valid;
            frame_start_q  <= frame_start;
            frame_start_qq <= frame_start_q;
            frame_type_q   <= frame_type_i;
            wr2ddr_en_q    <= wr2ddr_en;
            state          <= state_d;
            cnt            <= cnt_d;
            acc_cnt        <= acc_cnt_d;
            tcnt           <= tcnt_d;
            store_r        <= store_d;
            short_flag     <= short_flag_d;
            ovf_frame      <= ovf_frame_d;
            cur_type       <= cur_type_d;
            fifo_wrdata    <= fifo_wrdata_d;
            fifo_wren      <= fifo_wren_d;
            fifo_overflow  <= fifo_overflow_d;
            frame_store    <= frame_store_d;
            frame_type_o   <= frame_type_o_d;
            frame_seq_o    <= frame_seq_d;
            short_frame_o  <= short_frame_d;
        end
    end

endmodule
